// File: rtl/resampler_pkg.sv
// resampler_pkg: constants shared by resampler_1ch and the frame scheduler
package resampler_pkg;
  localparam int SAMPLE_W = 24;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_NEXT    = 3'd3;
  localparam logic [2:0] ST_PRESENT = 3'd4;
  localparam int FIR_TAPS = 16;
  localparam int FIR_PHASES = 8;
  localparam int COEF_W = 18;
  localparam int ACC_W = SAMPLE_W + COEF_W + $clog2(FIR_TAPS);
  typedef logic [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/resampler_sched.sv
// resampler_sched: pops each resampler channel in turn per tick and hands the mixer one frame
module resampler_sched
  import resampler_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int NUM_CH_LOG2  = 1,
  parameter int TIMEOUT      = 64,
  parameter int TIMEOUT_LOG2 = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick_i,
  output logic [NUM_CH-1:0]          pop_o,
  input  logic [NUM_CH-1:0]          ack_i,
  input  logic [SAMPLE_W*NUM_CH-1:0] data_i,
  output logic                       frame_valid_o,
  input  logic                       frame_ready_i,
  output logic [SAMPLE_W*NUM_CH-1:0] frame_data_o,
  output logic                       overrun_o,
  output logic                       timeout_o,
  input  logic                       clr_err_i
);
  logic [2:0] state_q, state_d;
  logic [NUM_CH_LOG2-1:0] ch_q, ch_d;
  logic [TIMEOUT_LOG2-1:0] cnt_q, cnt_d;
  logic [SAMPLE_W*NUM_CH-1:0] frame_q, frame_d;
  logic ovr_q, ovr_d, to_q, to_d;
  logic ack, last, expired;
  assign ack = ack_i[ch_q];
  assign last = ch_q == NUM_CH_LOG2'(NUM_CH - 1);
  assign expired = cnt_q == TIMEOUT_LOG2'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    cnt_d = cnt_q;
    frame_d = frame_q;
    ovr_d = (tick_i && state_q != ST_IDLE) || (ovr_q && !clr_err_i);
    to_d = to_q && !clr_err_i;
    case (state_q)
      ST_IDLE: if (tick_i) begin
        state_d = ST_ISSUE;
        ch_d = '0;
      end
      ST_ISSUE: begin
        cnt_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: if (ack) begin
        frame_d[SAMPLE_W*int'(ch_q) +: SAMPLE_W] = data_i[SAMPLE_W*int'(ch_q) +: SAMPLE_W];
        state_d = ST_NEXT;
      end else if (expired) begin
        frame_d[SAMPLE_W*int'(ch_q) +: SAMPLE_W] = '0;
        to_d = 1'b1;
        state_d = ST_NEXT;
      end else begin
        cnt_d = cnt_q + TIMEOUT_LOG2'(1);
      end
      ST_NEXT: begin
        state_d = last ? ST_PRESENT : ST_ISSUE;
        ch_d = last ? ch_q : ch_q + NUM_CH_LOG2'(1);
      end
      ST_PRESENT: if (frame_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ch_q <= '0;
      cnt_q <= '0;
      frame_q <= '0;
      ovr_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      cnt_q <= cnt_d;
      frame_q <= frame_d;
      ovr_q <= ovr_d;
      to_q <= to_d;
    end
  end
  // pop comes straight from registers so it is glitch-free and one-hot by construction
  assign pop_o = (state_q == ST_ISSUE) ? NUM_CH'(1) << ch_q : '0;
  assign frame_valid_o = state_q == ST_PRESENT;
  assign frame_data_o = frame_q;
  assign overrun_o = ovr_q;
  assign timeout_o = to_q;
endmodule

// File: tb/tb_resampler_sched.sv
// tb_resampler_sched: directed vector table plus hand-written corner sequences
module tb_resampler_sched;
  import resampler_pkg::*;
  localparam int TO = 64;
  localparam int NEVER = 999;
  logic clk = 1'b0;
  logic rst, tick_i, frame_ready_i, clr_err_i;
  logic [1:0] ack_i, pop_o;
  logic [47:0] data_i, frame_data_o;
  logic frame_valid_o, overrun_o, timeout_o;
  int errs = 0;
  int checks = 0;
  always #5 clk = ~clk;
  resampler_sched #(.NUM_CH(2), .NUM_CH_LOG2(1), .TIMEOUT(TO), .TIMEOUT_LOG2(6)) dut (
    .clk(clk), .rst(rst), .tick_i(tick_i), .pop_o(pop_o), .ack_i(ack_i), .data_i(data_i),
    .frame_valid_o(frame_valid_o), .frame_ready_i(frame_ready_i), .frame_data_o(frame_data_o),
    .overrun_o(overrun_o), .timeout_o(timeout_o), .clr_err_i(clr_err_i)
  );
  typedef struct {
    int d0;
    int d1;
    logic [23:0] v0;
    logic [23:0] v1;
    logic [47:0] exp_data;
    logic exp_to;
    int exp_lat;
  } vec_t;
  vec_t vecs[6];
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // drives a tick, answers each pop after the given number of WAIT cycles, stops at frame_valid
  task automatic run_frame(input int d0, input int d1, input logic [23:0] v0, input logic [23:0] v1,
                           input bit clr_on_to, output int lat, output int npop, output int first);
    int dly[2];
    int cur, w;
    dly[0] = d0;
    dly[1] = d1;
    cur = -1;
    w = 0;
    npop = 0;
    first = -1;
    data_i = {v1, v0};
    tick_i = 1'b1;
    step;
    tick_i = 1'b0;
    lat = 1;
    while (!frame_valid_o && lat < 400) begin
      ack_i = '0;
      clr_err_i = 1'b0;
      if (pop_o != '0) begin
        npop++;
        cur = pop_o[1] ? 1 : 0;
        w = 0;
        if (first < 0) first = cur;
      end else if (cur >= 0) begin
        if (w == dly[cur]) begin
          ack_i[cur] = 1'b1;
          cur = -1;
        end else if (w == TO - 1) begin
          clr_err_i = clr_on_to;
          cur = -1;
        end else begin
          w++;
        end
      end
      step;
      lat++;
    end
    ack_i = '0;
    clr_err_i = 1'b0;
  endtask
  initial begin
    int lat, np, fc, nv;
    logic [47:0] held;
    rst = 1'b1;
    tick_i = 1'b0;
    ack_i = '0;
    data_i = '0;
    frame_ready_i = 1'b0;
    clr_err_i = 1'b0;
    vecs[0] = '{0, 0, 24'h123456, 24'hABCDEF, 48'hABCDEF_123456, 1'b0, 7};
    vecs[1] = '{3, 1, 24'h111111, 24'h222222, 48'h222222_111111, 1'b0, 11};
    vecs[2] = '{0, NEVER, 24'h333333, 24'h444444, 48'h000000_333333, 1'b1, 70};
    vecs[3] = '{0, TO - 1, 24'h555555, 24'h666666, 48'h666666_555555, 1'b0, 70};
    vecs[4] = '{NEVER, NEVER, 24'h777777, 24'h888888, 48'h0, 1'b1, 133};
    vecs[5] = '{5, 0, 24'h9ABCDE, 24'hF01234, 48'hF01234_9ABCDE, 1'b0, 12};
    #3;
    check("reset pop", pop_o, 0);
    check("reset valid", frame_valid_o, 0);
    check("reset data", frame_data_o, 0);
    check("reset flags", {overrun_o, timeout_o}, 0);
    #9 rst = 1'b0;
    step;
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].d0, vecs[i].d1, vecs[i].v0, vecs[i].v1, 1'b0, lat, np, fc);
      check($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d pops", i), np, 2);
      check($sformatf("v%0d first ch", i), fc, 0);
      check($sformatf("v%0d data", i), frame_data_o, vecs[i].exp_data);
      check($sformatf("v%0d timeout", i), timeout_o, vecs[i].exp_to);
      check($sformatf("v%0d overrun", i), overrun_o, 0);
      frame_ready_i = 1'b1;
      step;
      frame_ready_i = 1'b0;
      check($sformatf("v%0d valid drop", i), frame_valid_o, 0);
      check($sformatf("v%0d data hold", i), frame_data_o, vecs[i].exp_data);
      clr_err_i = 1'b1;
      step;
      clr_err_i = 1'b0;
    end
    run_frame(0, 0, 24'h0A0A0A, 24'h0B0B0B, 1'b0, lat, np, fc);
    np = 0;
    for (int c = 0; c < 20; c++) begin
      tick_i = (c == 5);
      if (pop_o != '0) np++;
      step;
    end
    tick_i = 1'b0;
    check("ovr flag", overrun_o, 1);
    check("ovr no pops", np, 0);
    check("ovr valid held", frame_valid_o, 1);
    check("ovr data stable", frame_data_o, 48'h0B0B0B_0A0A0A);
    frame_ready_i = 1'b1;
    step;
    frame_ready_i = 1'b0;
    np = 0;
    nv = 0;
    for (int c = 0; c < 10; c++) begin
      if (pop_o != '0) np++;
      if (frame_valid_o) nv++;
      step;
    end
    check("ovr single frame", nv, 0);
    check("ovr dropped tick", np, 0);
    clr_err_i = 1'b1;
    step;
    clr_err_i = 1'b0;
    check("ovr cleared", overrun_o, 0);
    run_frame(0, 0, 24'h0C0C0C, 24'h0D0D0D, 1'b0, lat, np, fc);
    frame_ready_i = 1'b1;
    tick_i = 1'b1;
    step;
    frame_ready_i = 1'b0;
    tick_i = 1'b0;
    check("hs tick overrun", overrun_o, 1);
    check("hs valid drop", frame_valid_o, 0);
    np = 0;
    for (int c = 0; c < 10; c++) begin
      if (pop_o != '0) np++;
      step;
    end
    check("hs tick dropped", np, 0);
    data_i = {24'h111111, 24'h999999};
    ack_i = 2'b01;
    step;
    ack_i = '0;
    step;
    check("idle ack ignored", frame_data_o, 48'h0D0D0D_0C0C0C);
    data_i = {24'hDDDDDD, 24'hCCCCCC};
    tick_i = 1'b1;
    step;
    tick_i = 1'b0;
    check("stray pop0", pop_o, 2'b01);
    step;
    ack_i = 2'b10;
    step;
    ack_i = '0;
    check("stray ack1 ignored", frame_data_o, 48'h0D0D0D_0C0C0C);
    check("stray still waiting", pop_o, 0);
    ack_i = 2'b01;
    step;
    ack_i = '0;
    data_i = {24'hEEEEEE, 24'hCCCCCC};
    step;
    check("stray pop1", pop_o, 2'b10);
    step;
    ack_i = 2'b10;
    step;
    ack_i = '0;
    step;
    check("stray valid", frame_valid_o, 1);
    check("stray data", frame_data_o, 48'hEEEEEE_CCCCCC);
    frame_ready_i = 1'b1;
    step;
    frame_ready_i = 1'b0;
    run_frame(0, NEVER, 24'h121212, 24'h343434, 1'b0, lat, np, fc);
    check("clr pre timeout", timeout_o, 1);
    check("clr pre overrun", overrun_o, 1);
    frame_ready_i = 1'b1;
    step;
    frame_ready_i = 1'b0;
    clr_err_i = 1'b1;
    step;
    clr_err_i = 1'b0;
    check("clr alone", {overrun_o, timeout_o}, 0);
    run_frame(0, NEVER, 24'h565656, 24'h787878, 1'b1, lat, np, fc);
    check("clr vs timeout", timeout_o, 1);
    check("clr vs timeout data", frame_data_o, 48'h000000_565656);
    frame_ready_i = 1'b1;
    step;
    frame_ready_i = 1'b0;
    held = frame_data_o;
    check("rst pre data", held != 0, 1);
    tick_i = 1'b1;
    step;
    tick_i = 1'b0;
    step;
    #2 rst = 1'b1;
    #1;
    check("rst pop", pop_o, 0);
    check("rst valid", frame_valid_o, 0);
    check("rst flags", {overrun_o, timeout_o}, 0);
    check("rst data", frame_data_o, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    step;
    run_frame(0, 0, 24'h246810, 24'h13579B, 1'b0, lat, np, fc);
    check("post rst latency", lat, 7);
    check("post rst first ch", fc, 0);
    check("post rst data", frame_data_o, 48'h13579B_246810);
    frame_ready_i = 1'b1;
    step;
    frame_ready_i = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/resampler_sched.md
# resampler_sched

Frame scheduler that sequences NUM_CH `resampler_1ch` instances on behalf of the mixer. On each sample-rate tick it pops the channels one at a time, in ascending order. It collects each channel's 24-bit result, or substitutes zero if the channel does not answer in time. It then presents the complete frame to the mixer with a valid/ready handshake. It sits between the per-channel resamplers and the mixer, and owns every `pop_i` and `ack_o` wire between them.

## Interface
- NUM_CH, 2, number of resampler channels served (≥1)
- NUM_CH_LOG2, 1, width of the channel index (≥1)
- TIMEOUT, 64, maximum WAIT cycles per channel (≥2)
- TIMEOUT_LOG2, 6, width of the timeout counter
- clk  in  1  system clock; one clock domain only
- rst  in  1  reset, asynchronous, active-high
- tick_i  in  1  one-cycle frame-start strobe at the output sample rate
- pop_o  out  NUM_CH  one-hot pop request, one bit per resampler `pop_i`
- ack_i  in  NUM_CH  per-channel ack from resampler `ack_o`
- data_i  in  24*NUM_CH  per-channel result; channel k occupies bits [24k+23:24k]
- frame_valid_o  out  1  frame available to the mixer
- frame_ready_i  in  1  mixer accepts the frame
- frame_data_o  out  24*NUM_CH  frame samples, same packing as data_i
- overrun_o  out  1  sticky: a tick arrived while the scheduler was busy
- timeout_o  out  1  sticky: at least one channel timed out
- clr_err_i  in  1  clears both sticky flags

## Operation
- States:
  - IDLE: waits for tick_i; on tick, ch_idx←0, go to ISSUE.
  - ISSUE: pop_o[ch_idx]=1 for this cycle only; wait counter←0; go to WAIT.
  - WAIT:
    - ack_i[ch_idx]=1: latch data_i slot ch_idx into frame slot ch_idx; go to NEXT.
    - Otherwise, counter==TIMEOUT-1: frame slot←0, set timeout_o, go to NEXT.
    - Otherwise: counter+1, stay in WAIT.
  - NEXT: if ch_idx==NUM_CH-1 go to PRESENT; otherwise ch_idx+1 and go to ISSUE.
  - PRESENT: frame_valid_o=1; when frame_ready_i=1, go to IDLE.
- pop_o is decoded from state and ch_idx registers only. It is zero outside ISSUE, and at most one bit is ever set.
- Acks on channels other than ch_idx, or in any state other than WAIT, are ignored.
- An ack and a timeout in the same WAIT cycle: the ack wins, the data is latched and timeout_o is not set.
- tick_i in any state other than IDLE is dropped, not queued, and sets overrun_o. This includes the PRESENT cycle in which the handshake completes.
- clr_err_i clears overrun_o and timeout_o. A set event in the same cycle wins over the clear.
- frame_data_o holds its value from PRESENT entry until the next latch in WAIT. It is stable while frame_valid_o=1.
- Each resampler returns its previous computation at ack time, so the frame carries data one frame old. This is accepted behaviour.

## Timing
- Reset values: state=IDLE, ch_idx=0, counter=0, pop_o=0, frame_valid_o=0, frame_data_o=0, overrun_o=0, timeout_o=0.
- Reset mid-frame aborts immediately; no partial frame is presented.
- With all channels answering, per channel: tick sampled in IDLE at cycle t, pop_o at t+1, ack at t+2, NEXT at t+3, next ISSUE at t+4.
- frame_valid_o first goes high at cycle t+1+3·NUM_CH, i.e. t+7 for NUM_CH=2.
- Worst case (all channels time out): frame_valid_o rises at t+1+NUM_CH·(TIMEOUT+2).
- frame_valid_o stays high with no ready timeout. The mixer is responsible for draining frames.
- Minimum tick spacing for overrun-free operation: 2+3·NUM_CH cycles with zero ready stall.

## Structure
- Shared package `resampler_pkg` holds:
  - SAMPLE_W=24;
  - the scheduler state encoding (ST_IDLE=0, ST_ISSUE=1, ST_WAIT=2, ST_NEXT=3, ST_PRESENT=4, 3-bit);
  - the resampler FIR constants, so the scheduler and `resampler_1ch` agree.
- No sub-module. The state machine, timeout counter, frame register and sticky flags live in one module; NUM_CH instances of `resampler_1ch` are instantiated at the level above.

## Test plan
- Nominal frame: NUM_CH=2; tick at t; ch0 acks with 0x123456, ch1 with 0xABCDEF. Required: pop_o=01 at t+1, pop_o=10 at t+4, frame_valid_o at t+7, frame_data_o=0xABCDEF_123456, flags 0.
- Timeout: ch1 never acks. Required: pop_o=10 held for exactly 1 cycle; slot 1=0 after 64 WAIT cycles; timeout_o=1; frame still presented. Ack arriving on WAIT cycle 63 latches the data instead, with timeout_o=0.
- Overrun: ready held low 20 cycles after valid, second tick during PRESENT. Required: overrun_o=1, no extra pops, and only one frame delivered after ready.
- Stray acks: ack_i[1] pulses while ch0 is in WAIT, and ack_i[0] pulses in IDLE. Required: both ignored, frame data unchanged.
- Error clear: clr_err_i pulsed alone clears both flags; clr_err_i coincident with a timeout event leaves timeout_o=1.
- Async reset asserted mid-WAIT, off a clock edge. Required: pop_o=0, frame_valid_o=0, flags 0 immediately; the next tick starts cleanly at ch0.
